// File: rtl/asmd_dot_product_if.sv
// Operand-pair input and result handshake for the dot-product controller.
interface asmd_dot_product_if #(
  parameter int word_length = 4,
  parameter int guard_bits  = 4,
  parameter int count_width = 4
);
  logic                                in_valid;
  logic                                in_ready;
  logic [word_length-1:0]              in_a;
  logic [word_length-1:0]              in_b;
  logic                                in_last;
  logic [2*word_length+guard_bits-1:0] sum_out;
  logic                                sum_valid;
  logic                                sum_ack;
  logic [count_width-1:0]              pair_count;
  logic                                overflow;

  modport master (
    output in_valid, in_a, in_b, in_last, sum_ack,
    input  in_ready, sum_out, sum_valid, pair_count, overflow
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, sum_ack,
    output in_ready, sum_out, sum_valid, pair_count, overflow
  );
endinterface

// File: rtl/asmd_dot_product.sv
// Dot-product accumulator that sequences an external multi-cycle multiplier
// one operand pair at a time and holds the result until it is acknowledged.
//
// state     | meaning
// IDLE      | wait for a pair; in_ready follows mul_ready
// ISSUE     | one-cycle mul_start pulse with latched operands
// WAIT_BUSY | wait for the multiplier to drop mul_ready
// WAIT_DONE | wait for the multiplier to raise mul_ready again
// ACCUM     | add product into sum, bump pair count
// DONE      | result valid, held until sum_ack
module asmd_dot_product #(
  parameter int word_length = 4,
  parameter int guard_bits  = 4,
  parameter int count_width = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  asmd_dot_product_if.slave        bus,
  output logic [word_length-1:0]   mul_word0,
  output logic [word_length-1:0]   mul_word1,
  output logic                     mul_start,
  input  logic                     mul_ready,
  input  logic [2*word_length-1:0] mul_product
);

  localparam int sum_width = 2*word_length + guard_bits;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    ACCUM     = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t                 state, state_nxt;
  logic [word_length-1:0] a_q, b_q;
  logic                   last_q;
  logic [sum_width-1:0]   sum_q;
  logic [count_width-1:0] cnt_q;
  logic                   ovf_q;
  logic [sum_width:0]     acc_ext;
  logic                   in_ready_c, sum_valid_c;
  logic                   latch_en, accum_en, clear_en;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    sum_valid_c = 1'b0;
    mul_start   = 1'b0;
    latch_en    = 1'b0;
    accum_en    = 1'b0;
    clear_en    = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = mul_ready;
        if (bus.in_valid && mul_ready) begin
          latch_en  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mul_start = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: if (!mul_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (mul_ready)  state_nxt = ACCUM;
      ACCUM: begin
        accum_en  = 1'b1;
        state_nxt = last_q ? DONE : IDLE;
      end
      DONE: begin
        sum_valid_c = 1'b1;
        if (bus.sum_ack) begin
          clear_en  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One extra bit captures the carry that feeds the sticky overflow flag.
  assign acc_ext = {1'b0, sum_q} + {{(guard_bits+1){1'b0}}, mul_product};

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      last_q <= 1'b0;
      sum_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (latch_en) begin
        a_q    <= bus.in_a;
        b_q    <= bus.in_b;
        last_q <= bus.in_last;
      end
      if (accum_en) begin
        sum_q <= acc_ext[sum_width-1:0];
        cnt_q <= cnt_q + count_width'(1);
        ovf_q <= ovf_q | acc_ext[sum_width];
      end
      if (clear_en) begin
        sum_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end
    end
  end

  assign mul_word0      = a_q;
  assign mul_word1      = b_q;
  assign bus.in_ready   = in_ready_c;
  assign bus.sum_valid  = sum_valid_c;
  assign bus.sum_out    = sum_q;
  assign bus.pair_count = cnt_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_asmd_dot_product.sv
// Randomized bench for asmd_dot_product with a behavioural multiplier and
// a plain-arithmetic reference for the accumulated dot product.
module tb_asmd_dot_product;

  localparam int wl = 4;
  localparam int gb = 4;
  localparam int cw = 4;
  localparam int sum_mod = 1 << (2*wl + gb);
  localparam int cnt_mod = 1 << cw;

  logic            clk = 1'b0;
  logic            reset;
  logic [wl-1:0]   mul_word0, mul_word1;
  logic            mul_start;
  logic            mul_ready;
  logic [2*wl-1:0] mul_product = '0;

  asmd_dot_product_if #(.word_length(wl), .guard_bits(gb), .count_width(cw)) bus ();

  asmd_dot_product #(.word_length(wl), .guard_bits(gb), .count_width(cw)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .mul_word0   (mul_word0),
    .mul_word1   (mul_word1),
    .mul_start   (mul_start),
    .mul_ready   (mul_ready),
    .mul_product (mul_product)
  );

  always #5 clk = ~clk;

  // Multiplier model: drops ready the edge after start, returns after lat+1 edges.
  int            lat = 2;
  bit            mul_block = 1'b0;
  bit            m_idle = 1'b1;
  int            m_cnt = 0;
  logic [wl-1:0] m_a = '0, m_b = '0;
  int            start_cnt = 0;

  assign mul_ready = m_idle && !mul_block;

  always @(posedge clk) begin
    if (mul_start) begin
      start_cnt <= start_cnt + 1;
      m_idle    <= 1'b0;
      m_cnt     <= lat;
      m_a       <= mul_word0;
      m_b       <= mul_word1;
    end else if (!m_idle) begin
      if (m_cnt == 0) begin
        m_idle      <= 1'b1;
        mul_product <= m_a * m_b;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int qa[$];
  int qb[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_pair(input int a, input int b, input bit last);
    int t;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = wl'(a);
    bus.in_b     = wl'(b);
    bus.in_last  = last;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.sum_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!bus.sum_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic ack_and_check(input string tag);
    @(negedge clk);
    bus.sum_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.sum_ack = 1'b0;
    check({tag, "_clr_sum"},   bus.sum_out,    0);
    check({tag, "_clr_cnt"},   bus.pair_count, 0);
    check({tag, "_clr_ovf"},   bus.overflow,   0);
    check({tag, "_clr_valid"}, bus.sum_valid,  0);
  endtask

  // Sends the pairs in qa/qb as one vector; optionally pulses sum_ack while not in DONE.
  task automatic run_vec(input string tag, input bit ack_noise);
    int n, total, s0;
    n = qa.size();
    total = 0;
    s0 = start_cnt;
    for (int i = 0; i < n; i++) begin
      total += qa[i] * qb[i];
      bus.sum_ack = ack_noise && (i != n-1);
      send_pair(qa[i], qb[i], i == n-1);
      if (i != n-1) begin
        wait_ready();
        check({tag, "_early_valid"}, bus.sum_valid, 0);
      end
    end
    bus.sum_ack = 1'b0;
    wait_valid();
    check({tag, "_sum"},    bus.sum_out,        total % sum_mod);
    check({tag, "_cnt"},    bus.pair_count,     n % cnt_mod);
    check({tag, "_ovf"},    bus.overflow,       (total >= sum_mod) ? 1 : 0);
    check({tag, "_starts"}, start_cnt - s0,     n);
    ack_and_check(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_last  = 1'b0;
    bus.sum_ack  = 1'b0;
    reset        = 1'b0;
    mul_block    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sum",   bus.sum_out,    0);
    check("rst_cnt",   bus.pair_count, 0);
    check("rst_ovf",   bus.overflow,   0);
    check("rst_valid", bus.sum_valid,  0);
    check("rst_start", mul_start,      0);
    check("rst_w0",    mul_word0,      0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_wait_ready", bus.in_ready, 0);
    end
    mul_block = 1'b0;
    @(negedge clk);
    check("rst_ready", bus.in_ready, 1);

    // single pair 3*3
    qa = '{3}; qb = '{3};
    send_pair(3, 3, 1);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("single_hold_valid", bus.sum_valid, 1);
      check("single_sum", bus.sum_out, 9);
      check("single_cnt", bus.pair_count, 1);
    end
    check("single_starts", start_cnt, 1);
    ack_and_check("single");

    // (1,2),(3,4),(5,6) with sum_ack wiggling outside DONE
    qa = '{1, 3, 5}; qb = '{2, 4, 6};
    run_vec("vec3", 1'b1);

    // 17 and 19 pairs of (15,15): wrap of pair_count, then overflow
    qa = {}; qb = {};
    for (int i = 0; i < 17; i++) begin qa.push_back(15); qb.push_back(15); end
    run_vec("ovf17", 1'b0);
    qa.push_back(15); qb.push_back(15);
    qa.push_back(15); qb.push_back(15);
    run_vec("ovf19", 1'b0);

    // backpressure in DONE
    send_pair(7, 8, 1);
    wait_valid();
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a = wl'($urandom);
      bus.in_b = wl'($urandom);
      bus.in_last = 1'b1;
      check("bp_ready", bus.in_ready, 0);
      check("bp_sum",   bus.sum_out, 56);
      check("bp_valid", bus.sum_valid, 1);
    end
    check("bp_starts", start_cnt - s0, 0);
    bus.in_valid = 1'b0;
    ack_and_check("bp");

    // reset during WAIT_DONE of the second pair
    lat = 6;
    send_pair(3, 4, 0);
    wait_ready();
    send_pair(5, 5, 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_pre_sum", bus.sum_out, 12);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("mid_rst_sum",   bus.sum_out,    0);
    check("mid_rst_cnt",   bus.pair_count, 0);
    check("mid_rst_ovf",   bus.overflow,   0);
    check("mid_rst_valid", bus.sum_valid,  0);
    check("mid_rst_start", mul_start,      0);
    check("mid_rst_w0",    mul_word0,      0);
    check("mid_rst_w1",    mul_word1,      0);
    check("mid_rst_ready", bus.in_ready,   0);
    lat = 2;
    qa = '{2}; qb = '{7};
    run_vec("after_rst", 1'b0);

    // operand stability under a long multiply with toggling inputs
    lat = 8;
    send_pair(9, 6, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a = wl'(~i);
      bus.in_b = wl'(i);
      bus.in_last = 1'b0;
      check("stab_w0",    mul_word0,    9);
      check("stab_w1",    mul_word1,    6);
      check("stab_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    wait_valid();
    check("stab_sum", bus.sum_out, 54);
    check("stab_cnt", bus.pair_count, 1);
    ack_and_check("stab");

    // random vectors, random multiplier latency
    for (int v = 0; v < 8; v++) begin
      int n;
      n = $urandom_range(1, 20);
      lat = $urandom_range(0, 4);
      qa = {}; qb = {};
      for (int i = 0; i < n; i++) begin
        qa.push_back($urandom_range(0, 15));
        qb.push_back($urandom_range(0, 15));
      end
      run_vec("rand", v[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
